// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: funct3 access
// types, FSM state encoding and the request error predicate.
package data_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_t;

  function automatic logic isIllegalType(input logic we, input logic [2:0] memType);
    logic illegal;
    illegal = 1'b0;
    case (memType)
      MEM_B, MEM_H, MEM_W: illegal = 1'b0;
      MEM_BU, MEM_HU:      illegal = we;
      default:             illegal = 1'b1;
    endcase
    return illegal;
  endfunction

  // Any single condition turns the access into an error response with no array write.
  function automatic logic memErr(input logic we, input logic [2:0] memType,
                                  input logic outOfRange, input logic misaligned);
    return outOfRange | misaligned | isIllegalType(we, memType);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Valid/ready request and response channels of the core's data-memory port.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_type;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian lane steering: store byte mask and replicated write data,
// load extraction with sign/zero extension, and alignment check.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  memType,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdataLane,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal = rword[{addr, 3'b000} +: 8];
    halfVal = addr[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    wmask      = 4'b0000;
    wdataLane  = 32'h0;
    loadData   = 32'h0;
    misaligned = 1'b0;
    case (memType)
      MEM_B: begin
        wmask     = 4'b0001 << addr;
        wdataLane = {4{wdata[7:0]}};
        loadData  = {{24{byteVal[7]}}, byteVal};
      end
      MEM_BU: begin
        loadData = {24'h0, byteVal};
      end
      MEM_H: begin
        misaligned = addr[0];
        wmask      = addr[1] ? 4'b1100 : 4'b0011;
        wdataLane  = {2{wdata[15:0]}};
        loadData   = {{16{halfVal[15]}}, halfVal};
      end
      MEM_HU: begin
        misaligned = addr[0];
        loadData   = {16'h0, halfVal};
      end
      MEM_W: begin
        misaligned = (addr != 2'b00);
        wmask      = 4'b1111;
        wdataLane  = wdata;
        loadData   = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, committed at
// the accept edge, response returned LATENCY cycles later.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | access committed, latency counter running down
//   RESP  | rsp_valid high, response held until rsp_ready
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       CLK,
  input  logic       RESET,
  data_mem_if.slave  bus,
  output logic [7:0] err_count
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  memState_t   state;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic [7:0]  errCount;
  logic [3:0]  latCount;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]      wordOff;
  logic [IDX_W-1:0] wordIdx;
  logic             outOfRange;
  logic [31:0]      rword;
  logic [3:0]       wmask;
  logic [31:0]      wdataLane;
  logic [31:0]      loadData;
  logic             misaligned;
  logic             reqErr;
  logic             accept;
  logic             storeEn;

  // BASE_ADDR is word-aligned, so the word offset only needs the upper 30 bits.
  always_comb begin
    wordOff    = bus.req_addr[31:2] - BASE_ADDR[31:2];
    wordIdx    = wordOff[IDX_W-1:0];
    outOfRange = (bus.req_addr < BASE_ADDR) || (wordOff[29:IDX_W] != '0);
    rword      = mem[wordIdx];
  end

  mem_lane_align u_lane (
    .addr       (bus.req_addr[1:0]),
    .memType    (bus.req_type),
    .wdata      (bus.req_wdata),
    .rword      (rword),
    .wmask      (wmask),
    .wdataLane  (wdataLane),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  always_comb begin
    reqErr  = memErr(bus.req_we, bus.req_type, outOfRange, misaligned);
    accept  = bus.req_valid & reqReady;
    storeEn = accept & bus.req_we & ~reqErr;
  end

  // Backing array is deliberately not reset; a committed store survives a reset.
  always_ff @(posedge CLK) begin
    if (storeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[wordIdx][8*b +: 8] <= wdataLane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      reqReady <= 1'b0;
      rspValid <= 1'b0;
      rspData  <= 32'h0;
      rspErr   <= 1'b0;
      errCount <= 8'h0;
      latCount <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WAIT;
            reqReady <= 1'b0;
            latCount <= LAT_LOAD;
            rspErr   <= reqErr;
            rspData  <= (reqErr || bus.req_we) ? 32'h0 : loadData;
          end else begin
            reqReady <= 1'b1;
          end
        end
        WAIT: begin
          if (latCount == 4'h0) begin
            state    <= RESP;
            rspValid <= 1'b1;
          end else begin
            latCount <= latCount - 4'h1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state    <= IDLE;
            rspValid <= 1'b0;
            reqReady <= 1'b1;
            if (rspErr && errCount != 8'hFF) errCount <= errCount + 8'h1;
          end
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b0;
          rspValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspData;
  assign bus.rsp_err   = rspErr;
  assign err_count     = errCount;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=2 instance for functional
// scenarios, LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  t;
    logic [31:0] expD;
    logic        expE;
  } req_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] errCountA;
  logic [7:0] errCountB;

  data_mem_if ifA ();
  data_mem_if ifB ();

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dutA (
    .CLK(CLK), .RESET(RESET), .bus(ifA), .err_count(errCountA)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) dutB (
    .CLK(CLK), .RESET(RESET), .bus(ifB), .err_count(errCountB)
  );

  always #5 CLK = ~CLK;

  exp_t sbA[$];
  exp_t sbB[$];
  int checks = 0;
  int passes = 0;

  task automatic sendA(input req_t r);
    int n;
    n = 0;
    ifA.req_we    = r.we;
    ifA.req_addr  = r.addr;
    ifA.req_wdata = r.wdata;
    ifA.req_type  = r.t;
    ifA.req_valid = 1'b1;
    while (ifA.req_ready !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      $display("FAIL accept_timeout req_ready=%b required=1", ifA.req_ready);
    end else begin
      sbA.push_back('{r.expD, r.expE});
      @(posedge CLK); #1;
    end
    ifA.req_valid = 1'b0;
  endtask

  task automatic getA(output logic [31:0] d, output logic e, output int lat);
    lat = 0;
    while (ifA.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    d = ifA.rsp_rdata;
    e = ifA.rsp_err;
    ifA.rsp_ready = 1'b1;
    @(posedge CLK); #1;
    ifA.rsp_ready = 1'b0;
  endtask

  task automatic runA(input req_t r, output logic [31:0] d, output logic e,
                      output int lat, output exp_t x);
    sendA(r);
    getA(d, e, lat);
    if (sbA.size() != 0) x = sbA.pop_front();
    else begin
      x.rdata = 'x;
      x.err   = 1'bx;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ifA.req_ready !== 1'b0) $display("FAIL rst_req_ready got=%b exp=0", ifA.req_ready); else passes++;
    checks++; if (ifA.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", ifA.rsp_valid); else passes++;
    checks++; if (ifA.rsp_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", ifA.rsp_rdata); else passes++;
    checks++; if (ifA.rsp_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", ifA.rsp_err); else passes++;
    checks++; if (errCountA !== 8'h0) $display("FAIL rst_err_count got=%0d exp=0", errCountA); else passes++;
    #10 RESET = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (ifA.req_ready !== 1'b1 || ifB.req_ready !== 1'b1)
      $display("FAIL rst_release_ready gotA=%b gotB=%b exp=1", ifA.req_ready, ifB.req_ready);
    else passes++;
  endtask

  task automatic test_store_load();
    req_t tbl[2] = '{
      '{1'b1, 32'h10, 32'hDEADBEEF, MEM_W, 32'h0, 1'b0},
      '{1'b0, 32'h10, 32'h0,        MEM_W, 32'hDEADBEEF, 1'b0}
    };
    logic [31:0] d; logic e; int lat; exp_t x;
    foreach (tbl[i]) begin
      runA(tbl[i], d, e, lat, x);
      checks++; if (lat !== 2) $display("FAIL sl_latency[%0d] got=%0d exp=2", i, lat); else passes++;
      checks++;
      if (d !== x.rdata || e !== x.err)
        $display("FAIL sl_rsp[%0d] rdata=%h err=%b exp rdata=%h err=%b", i, d, e, x.rdata, x.err);
      else passes++;
    end
  endtask

  task automatic test_lanes();
    req_t tbl[7] = '{
      '{1'b1, 32'h11, 32'h000000A5, MEM_B,  32'h0, 1'b0},
      '{1'b0, 32'h10, 32'h0,        MEM_W,  32'hDEADA5EF, 1'b0},
      '{1'b0, 32'h11, 32'h0,        MEM_B,  32'hFFFFFFA5, 1'b0},
      '{1'b0, 32'h11, 32'h0,        MEM_BU, 32'h000000A5, 1'b0},
      '{1'b0, 32'h12, 32'h0,        MEM_HU, 32'h0000DEAD, 1'b0},
      '{1'b1, 32'h16, 32'h12348001, MEM_H,  32'h0, 1'b0},
      '{1'b0, 32'h16, 32'h0,        MEM_H,  32'hFFFF8001, 1'b0}
    };
    logic [31:0] d; logic e; int lat; exp_t x;
    foreach (tbl[i]) begin
      runA(tbl[i], d, e, lat, x);
      checks++;
      if (d !== x.rdata || e !== x.err)
        $display("FAIL lanes[%0d] rdata=%h err=%b exp rdata=%h err=%b", i, d, e, x.rdata, x.err);
      else passes++;
    end
  endtask

  task automatic test_errors();
    req_t tbl[4] = '{
      '{1'b0, 32'h102, 32'h0,    MEM_W, 32'h0, 1'b1},
      '{1'b1, 32'h13,  32'hBEEF, MEM_H, 32'h0, 1'b1},
      '{1'b0, 32'h400, 32'h0,    MEM_W, 32'h0, 1'b1},
      '{1'b0, 32'h10,  32'h0,    MEM_W, 32'hDEADA5EF, 1'b0}
    };
    logic [31:0] d; logic e; int lat; exp_t x;
    foreach (tbl[i]) begin
      runA(tbl[i], d, e, lat, x);
      checks++;
      if (d !== x.rdata || e !== x.err)
        $display("FAIL errors[%0d] rdata=%h err=%b exp rdata=%h err=%b", i, d, e, x.rdata, x.err);
      else passes++;
    end
    checks++; if (errCountA !== 8'd3) $display("FAIL err_count_3 got=%0d exp=3", errCountA); else passes++;
  endtask

  task automatic test_illegal_type();
    req_t tbl[5] = '{
      '{1'b0, 32'h10, 32'h0,  3'b011, 32'h0, 1'b1},
      '{1'b1, 32'h10, 32'hFF, MEM_BU, 32'h0, 1'b1},
      '{1'b1, 32'h10, 32'hFF, MEM_HU, 32'h0, 1'b1},
      '{1'b0, 32'h10, 32'h0,  3'b110, 32'h0, 1'b1},
      '{1'b0, 32'h10, 32'h0,  MEM_W,  32'hDEADA5EF, 1'b0}
    };
    logic [31:0] d; logic e; int lat; exp_t x;
    foreach (tbl[i]) begin
      runA(tbl[i], d, e, lat, x);
      checks++;
      if (d !== x.rdata || e !== x.err)
        $display("FAIL illegal[%0d] rdata=%h err=%b exp rdata=%h err=%b", i, d, e, x.rdata, x.err);
      else passes++;
    end
    checks++; if (errCountA !== 8'd7) $display("FAIL err_count_7 got=%0d exp=7", errCountA); else passes++;
  endtask

  task automatic test_backpressure();
    req_t r = '{1'b0, 32'h10, 32'h0, MEM_W, 32'hDEADA5EF, 1'b0};
    exp_t x;
    int n;
    sendA(r);
    n = 0;
    while (ifA.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sbA.size() != 0) x = sbA.pop_front();
    else begin
      x.rdata = 'x;
      x.err   = 1'bx;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ifA.rsp_valid !== 1'b1 || ifA.rsp_rdata !== x.rdata || ifA.rsp_err !== x.err || ifA.req_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] valid=%b rdata=%h err=%b ready=%b exp valid=1 rdata=%h err=%b ready=0",
                 c, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err, ifA.req_ready, x.rdata, x.err);
      else passes++;
      @(posedge CLK); #1;
    end
    ifA.rsp_ready = 1'b1;
    @(posedge CLK); #1;
    ifA.rsp_ready = 1'b0;
    checks++;
    if (ifA.req_ready !== 1'b1 || ifA.rsp_valid !== 1'b0)
      $display("FAIL bp_release ready=%b valid=%b exp ready=1 valid=0", ifA.req_ready, ifA.rsp_valid);
    else passes++;
  endtask

  task automatic test_reset_mid_wait();
    req_t tbl[2] = '{
      '{1'b0, 32'h20, 32'h0, MEM_W, 32'h12345678, 1'b0},
      '{1'b0, 32'h10, 32'h0, MEM_W, 32'hDEADA5EF, 1'b0}
    };
    logic [31:0] d; logic e; int lat; exp_t x;
    int n;
    bit seen;
    ifA.req_we    = 1'b1;
    ifA.req_addr  = 32'h20;
    ifA.req_wdata = 32'h12345678;
    ifA.req_type  = MEM_W;
    ifA.req_valid = 1'b1;
    n = 0;
    while (ifA.req_ready !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    @(posedge CLK); #1;
    ifA.req_valid = 1'b0;
    RESET = 1'b0;
    #1;
    checks++;
    if (ifA.rsp_valid !== 1'b0 || ifA.req_ready !== 1'b0 || errCountA !== 8'h0)
      $display("FAIL rmw_in_reset valid=%b ready=%b err_count=%0d exp 0 0 0", ifA.rsp_valid, ifA.req_ready, errCountA);
    else passes++;
    #10 RESET = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (ifA.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rmw_dropped rsp_valid_seen=%b exp=0", seen); else passes++;
    foreach (tbl[i]) begin
      runA(tbl[i], d, e, lat, x);
      checks++;
      if (d !== x.rdata || e !== x.err)
        $display("FAIL rmw_load[%0d] rdata=%h err=%b exp rdata=%h err=%b", i, d, e, x.rdata, x.err);
      else passes++;
    end
    checks++; if (errCountA !== 8'h0) $display("FAIL rmw_err_count got=%0d exp=0", errCountA); else passes++;
  endtask

  task automatic test_back_to_back();
    req_t tbl[4] = '{
      '{1'b1, 32'h40, 32'hCAFEF00D, MEM_W,  32'h0, 1'b0},
      '{1'b0, 32'h40, 32'h0,        MEM_W,  32'hCAFEF00D, 1'b0},
      '{1'b0, 32'h43, 32'h0,        MEM_B,  32'hFFFFFFCA, 1'b0},
      '{1'b0, 32'h40, 32'h0,        MEM_HU, 32'h0000F00D, 1'b0}
    };
    int idx;
    int lastAcc;
    int c;
    exp_t x;
    idx = 0;
    lastAcc = -100;
    c = 0;
    ifB.rsp_ready = 1'b1;
    while (c < 40 && (idx < 4 || sbB.size() != 0)) begin
      if (ifB.rsp_valid === 1'b1) begin
        if (sbB.size() != 0) x = sbB.pop_front();
        else begin
          x.rdata = 'x;
          x.err   = 1'bx;
        end
        checks++;
        if (ifB.rsp_rdata !== x.rdata || ifB.rsp_err !== x.err)
          $display("FAIL b2b_rsp rdata=%h err=%b exp rdata=%h err=%b", ifB.rsp_rdata, ifB.rsp_err, x.rdata, x.err);
        else passes++;
        checks++;
        if (c - lastAcc !== 2) $display("FAIL b2b_rsp_timing cycles=%0d exp=2", c - lastAcc); else passes++;
      end
      if (idx < 4) begin
        ifB.req_we    = tbl[idx].we;
        ifB.req_addr  = tbl[idx].addr;
        ifB.req_wdata = tbl[idx].wdata;
        ifB.req_type  = tbl[idx].t;
        ifB.req_valid = 1'b1;
        if (ifB.req_ready === 1'b1) begin
          if (idx > 0) begin
            checks++;
            if (c - lastAcc !== 3) $display("FAIL b2b_period cycles=%0d exp=3", c - lastAcc); else passes++;
          end
          lastAcc = c;
          sbB.push_back('{tbl[idx].expD, tbl[idx].expE});
          idx++;
        end
      end else begin
        ifB.req_valid = 1'b0;
      end
      @(posedge CLK); #1;
      c++;
    end
    ifB.req_valid = 1'b0;
    if (idx < 4 || sbB.size() != 0) begin
      checks++;
      $display("FAIL b2b_timeout issued=%0d pending=%0d exp issued=4 pending=0", idx, sbB.size());
    end
  endtask

  initial begin
    ifA.req_valid = 1'b0; ifA.req_we = 1'b0; ifA.req_addr = 32'h0;
    ifA.req_wdata = 32'h0; ifA.req_type = MEM_W; ifA.rsp_ready = 1'b0;
    ifB.req_valid = 1'b0; ifB.req_we = 1'b0; ifB.req_addr = 32'h0;
    ifB.req_wdata = 32'h0; ifB.req_type = MEM_W; ifB.rsp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_lanes();
    test_errors();
    test_illegal_type();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder (slave) end of the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake, applies RISC-V byte/halfword/word lane handling (funct3-encoded type), and returns read data or an error after a fixed, configurable latency. It replaces the zero-latency data memory so the pipeline can be verified against a realistic multi-cycle memory.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two).
LATENCY, 2, cycles from the request-accept edge to rsp_valid assertion; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; word-aligned.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
req_type  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or illegal type
err_count  output  8  saturating count of error responses

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; req_ready=0 while RESET is low and 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0, latency counter=0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid & req_ready at a clock edge, go to WAIT and load the counter with LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 0, go to RESP with rsp_valid=1 on the next edge. With LATENCY=1, rsp_valid is 1 in the cycle right after accept.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready. On handshake, go to IDLE. A new request cannot be accepted in the same cycle; there is one outstanding request maximum.
- Access commit: at the accept edge the request is decoded, any store is written, and the load word is read and formatted into the response register. A following load observes a preceding store.
- Word index = (req_addr - BASE_ADDR) >> 2.
- Error conditions (any one sets rsp_err=1; no array write; rsp_rdata=0):
  - out of range: req_addr < BASE_ADDR, or word index >= DEPTH_WORDS;
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - illegal type: req_type in {011, 110, 111}, or a store with BU/HU (100/101).
- Lanes: little-endian; byte lane = addr[1:0], half lane = addr[1].
  - SB/SH use per-byte write enables; other bytes are unchanged.
  - Loads: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- err_count increments at each error response handshake and saturates at 255.
- Reset mid-operation (WAIT or RESP): the pending response is dropped. A store already committed at its accept edge remains in the array.
- Changes to req_* while req_ready=0 are ignored. rsp_ready while rsp_valid=0 is ignored.

Decomposition:
- Shared package data_mem_pkg:
  - funct3 constants MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU;
  - state typedef {IDLE, WAIT, RESP};
  - function for the error predicate.
- One combinational sub-module, mem_lane_align. Inputs: addr[1:0], type, wdata, rword. Outputs: 4-bit byte write mask, lane-shifted write data, extended load data, misaligned flag.
- The top module holds the FSM, counter, array and response registers.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10, LATENCY=2 -> rsp_valid exactly 2 cycles after each accept; rdata 0xDEADBEEF; rsp_err=0.
- SB 0x11 data 0x000000A5 after the above, then LW 0x10 -> 0xDEADA5EF. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5. LHU 0x12 -> 0x0000DEAD.
- LW 0x102, SH 0x13, and LW at BASE_ADDR+4*DEPTH_WORDS -> each gives rsp_err=1, rdata=0. A follow-up LW 0x10 shows the word unchanged. err_count=3.
- Backpressure: rsp_ready held 0 for 3 cycles during RESP -> rsp_valid, rdata and err stay stable; req_ready=0 throughout; IDLE is reached one cycle after rsp_ready=1.
- Reset mid-WAIT after SW 0x20 data 0x12345678: RESET pulsed low -> rsp_valid never asserts, err_count=0. After release, LW 0x20 -> 0x12345678.
- LATENCY=1 build, back-to-back LW with rsp_ready tied 1 -> accept, response and accept repeat every 3 cycles.
